// File: rtl/karatsuba_pipe_mul.sv
// Pipelined Karatsuba multiplier: C = A*B from three half-width products, with up to eight optional register stages.
// Latency is the number of enabled stages; a held output (out_valid && !out_ready) freezes every stage and drops in_ready.
module karatsuba_pipe_mul #(
   parameter int WA      = 66,
   parameter int WB      = 68,
   parameter int TAG_W   = 4,
   parameter int FF_IN   = 1,
   parameter int FF_SUM0 = 1,
   parameter int FF_SUB0 = 1,
   parameter int FF_MUL  = 1,
   parameter int FF_SUM1 = 1,
   parameter int FF_SUM2 = 1,
   parameter int FF_SUB1 = 1,
   parameter int FF_OUT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WA-1:0]      A,
   input  logic [WB-1:0]      B,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WA+WB-1:0]   C,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int W    = (WA > WB) ? WA : WB;
   localparam int H    = (W + 1) / 2;
   localparam int H2   = 2 * H;
   localparam int WT   = 2 * H + 1;
   localparam int WP   = 2 * H + 2;
   localparam int W4   = 4 * H;
   localparam int WACC = 4 * H + 2;
   localparam int WC   = WA + WB;
   localparam int L    = FF_IN + FF_SUM0 + FF_SUB0 + FF_MUL + FF_SUM1 + FF_SUM2 + FF_SUB1 + FF_OUT;

   typedef struct packed {
      logic [H-1:0] al;
      logic [H-1:0] ah;
      logic [H-1:0] bl;
      logic [H-1:0] bh;
   } ops_t;

   typedef struct packed {
      ops_t         ops;
      logic [H:0]   sa;
      logic [H:0]   sb;
   } pre_t;

   typedef struct packed {
      logic [H2-1:0] p0;
      logic [H2-1:0] p2;
      logic [WP-1:0] pm;
   } prod_t;

   typedef struct packed {
      logic [W4-1:0] outer;
      logic [WT-1:0] t;
      logic [WP-1:0] pm;
   } post_t;

   typedef struct packed {
      logic [WACC-1:0] acc;
      logic [WT-1:0]   t;
   } acc_t;

   logic stall;
   logic adv;

   // Operands are zero-extended to 2H so both split at the same H.
   logic [H2-1:0] a_ext;
   logic [H2-1:0] b_ext;
   assign a_ext = H2'(A);
   assign b_ext = H2'(B);

   ops_t             n1, d1;
   logic             v1;
   logic [TAG_W-1:0] g1;
   assign n1 = '{al: a_ext[H-1:0], ah: a_ext[H2-1:H], bl: b_ext[H-1:0], bh: b_ext[H2-1:H]};
   if (FF_IN != 0) begin : g_in
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v1 <= 1'b0;
         else if (adv) v1 <= in_valid;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d1 <= n1;
            g1 <= in_tag;
         end
      end
   end else begin : g_in_bypass
      assign v1 = in_valid;
      assign d1 = n1;
      assign g1 = in_tag;
   end

   pre_t             n2, d2;
   logic             v2;
   logic [TAG_W-1:0] g2;
   assign n2 = '{ops: d1, sa: {1'b0, d1.al} + {1'b0, d1.ah}, sb: {1'b0, d1.bl} + {1'b0, d1.bh}};
   if (FF_SUM0 != 0) begin : g_sum0
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v2 <= 1'b0;
         else if (adv) v2 <= v1;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d2 <= n2;
            g2 <= g1;
         end
      end
   end else begin : g_sum0_bypass
      assign v2 = v1;
      assign d2 = n2;
      assign g2 = g1;
   end

   // Retiming slot ahead of the multipliers; carries the pre-added operands unchanged.
   pre_t             d3;
   logic             v3;
   logic [TAG_W-1:0] g3;
   if (FF_SUB0 != 0) begin : g_sub0
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v3 <= 1'b0;
         else if (adv) v3 <= v2;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d3 <= d2;
            g3 <= g2;
         end
      end
   end else begin : g_sub0_bypass
      assign v3 = v2;
      assign d3 = d2;
      assign g3 = g2;
   end

   prod_t            n4, d4;
   logic             v4;
   logic [TAG_W-1:0] g4;
   assign n4 = '{p0: H2'(d3.ops.al) * H2'(d3.ops.bl),
                 p2: H2'(d3.ops.ah) * H2'(d3.ops.bh),
                 pm: WP'(d3.sa) * WP'(d3.sb)};
   if (FF_MUL != 0) begin : g_mul
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v4 <= 1'b0;
         else if (adv) v4 <= v3;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d4 <= n4;
            g4 <= g3;
         end
      end
   end else begin : g_mul_bypass
      assign v4 = v3;
      assign d4 = n4;
      assign g4 = g3;
   end

   // P0 < 2^2H, so P2<<2H + P0 is a plain concatenation.
   post_t            n5, d5;
   logic             v5;
   logic [TAG_W-1:0] g5;
   assign n5 = '{outer: {d4.p2, d4.p0}, t: WT'(d4.p0) + WT'(d4.p2), pm: d4.pm};
   if (FF_SUM1 != 0) begin : g_sum1
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v5 <= 1'b0;
         else if (adv) v5 <= v4;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d5 <= n5;
            g5 <= g4;
         end
      end
   end else begin : g_sum1_bypass
      assign v5 = v4;
      assign d5 = n5;
      assign g5 = g4;
   end

   acc_t             n6, d6;
   logic             v6;
   logic [TAG_W-1:0] g6;
   assign n6 = '{acc: WACC'(d5.outer) + (WACC'(d5.pm) << H), t: d5.t};
   if (FF_SUM2 != 0) begin : g_sum2
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v6 <= 1'b0;
         else if (adv) v6 <= v5;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d6 <= n6;
            g6 <= g5;
         end
      end
   end else begin : g_sum2_bypass
      assign v6 = v5;
      assign d6 = n6;
      assign g6 = g5;
   end

   // Removing (P0+P2)<<H turns Pm<<H into the Karatsuba middle term; the result fits WC bits.
   logic [WACC-1:0]  diff7;
   logic [WC-1:0]    n7, d7;
   logic             v7;
   logic [TAG_W-1:0] g7;
   assign diff7 = d6.acc - (WACC'(d6.t) << H);
   assign n7    = WC'(diff7);
   if (FF_SUB1 != 0) begin : g_sub1
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v7 <= 1'b0;
         else if (adv) v7 <= v6;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d7 <= n7;
            g7 <= g6;
         end
      end
   end else begin : g_sub1_bypass
      assign v7 = v6;
      assign d7 = n7;
      assign g7 = g6;
   end

   logic [WC-1:0]    d8;
   logic             v8;
   logic [TAG_W-1:0] g8;
   if (FF_OUT != 0) begin : g_out
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     v8 <= 1'b0;
         else if (adv) v8 <= v7;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            d8 <= d7;
            g8 <= g7;
         end
      end
   end else begin : g_out_bypass
      assign v8 = v7;
      assign d8 = d7;
      assign g8 = g7;
   end

   assign out_valid = v8;
   assign C         = d8;
   assign out_tag   = g8;

   // With no registers the handshake is a straight wire; otherwise stall only depends on stage state.
   assign stall    = v8 && !out_ready;
   assign adv      = !stall;
   assign in_ready = (L == 0) ? out_ready : adv;

   assign busy = ((FF_IN   != 0) && v1) || ((FF_SUM0 != 0) && v2) ||
                 ((FF_SUB0 != 0) && v3) || ((FF_MUL  != 0) && v4) ||
                 ((FF_SUM1 != 0) && v5) || ((FF_SUM2 != 0) && v6) ||
                 ((FF_SUB1 != 0) && v7) || ((FF_OUT  != 0) && v8);

   logic unused_sink;
   assign unused_sink = ^{clk, rst, adv};

endmodule

// File: tb/tb_karatsuba_pipe_mul.sv
// Scoreboard bench: default 66x68 pipeline, a 33x31 combinational build and a 16x16 alternating-stage build.
module tb_karatsuba_pipe_mul;

   localparam int WA = 66;
   localparam int WB = 68;
   localparam int TW = 4;
   localparam int WC = WA + WB;
   localparam int L0 = 8;
   localparam int L2 = 4;

   typedef struct {
      logic [WC-1:0] c;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;

   logic clk;
   logic rst;

   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [WA-1:0] a;
   logic [WB-1:0] b;
   logic [TW-1:0] in_tag, out_tag;
   logic [WC-1:0] c;

   logic          v1, r1, ir1, ov1, bz1;
   logic [32:0]   a1;
   logic [30:0]   b1;
   logic [TW-1:0] t1, ot1;
   logic [63:0]   c1;

   logic          v2, r2, ir2, ov2, bz2;
   logic [15:0]   a2, b2;
   logic [TW-1:0] t2, ot2;
   logic [31:0]   c2;

   karatsuba_pipe_mul dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .C(c),
      .out_tag(out_tag), .busy(busy));

   karatsuba_pipe_mul #(.WA(33), .WB(31), .TAG_W(TW), .FF_IN(0), .FF_SUM0(0), .FF_SUB0(0),
      .FF_MUL(0), .FF_SUM1(0), .FF_SUM2(0), .FF_SUB1(0), .FF_OUT(0)) dut_comb (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .A(a1), .B(b1),
      .in_tag(t1), .out_valid(ov1), .out_ready(r1), .C(c1), .out_tag(ot1), .busy(bz1));

   karatsuba_pipe_mul #(.WA(16), .WB(16), .TAG_W(TW), .FF_IN(1), .FF_SUM0(0), .FF_SUB0(1),
      .FF_MUL(0), .FF_SUM1(1), .FF_SUM2(0), .FF_SUB1(1), .FF_OUT(0)) dut_alt (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .A(a2), .B(b2),
      .in_tag(t2), .out_valid(ov2), .out_ready(r2), .C(c2), .out_tag(ot2), .busy(bz2));

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   n_in = 0;
   int   n_out = 0;
   int   last_stall = -1;
   logic rdy_rand = 1'b0;
   logic watch_gap = 1'b0;
   logic seen_first = 1'b0;
   int   gaps = 0;
   int   last_out_cyc = 0;

   exp_t sb_q[$];
   exp_t q2[$];

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WC-1:0] ref_mul(input logic [WA-1:0] x, input logic [WB-1:0] y);
      logic [WC-1:0] xw, yw;
      xw = WC'(x);
      yw = WC'(y);
      return xw * yw;
   endfunction

   function automatic logic [WA-1:0] rand_a();
      return WA'({$urandom, $urandom, $urandom});
   endfunction

   function automatic logic [WB-1:0] rand_b();
      return WB'({$urandom, $urandom, $urandom});
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
      end
   end

   // Monitor for the default build: handshake invariant, hold stability, scoreboard order and latency.
   initial begin
      logic          prev_stall;
      logic [WC-1:0] prev_c;
      logic [TW-1:0] prev_tag;
      exp_t          e;
      prev_stall = 1'b0;
      prev_c     = '0;
      prev_tag   = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
               check("hold_valid", out_valid, 1'b1);
               check("hold_c", c, prev_c);
               check("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_result", 1'b1, 1'b0);
               end else begin
                  e = sb_q.pop_front();
                  check("result_c", c, e.c);
                  check("result_tag", out_tag, e.tag);
                  if (last_stall < e.cyc) check("latency", cyc - e.cyc, L0);
               end
               n_out++;
               if (watch_gap) begin
                  if (seen_first && cyc != last_out_cyc + 1) gaps++;
                  seen_first = 1'b1;
               end
               last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c;
            prev_tag   = out_tag;
            if (prev_stall) last_stall = cyc;
         end
      end
   end

   // Monitor for the 16x16 alternating build.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && ov2 && r2) begin
            if (q2.size() == 0) begin
               check("alt_unexpected", 1'b1, 1'b0);
            end else begin
               e = q2.pop_front();
               check("alt_c", c2, e.c);
               check("alt_tag", ot2, e.tag);
               check("alt_latency", cyc - e.cyc, L2);
            end
         end
      end
   end

   task automatic send(input logic [WA-1:0] x, input logic [WB-1:0] y, input logic [TW-1:0] t,
                       input logic [WC-1:0] e);
      int   waited;
      logic done;
      waited = 0;
      done   = 1'b0;
      a = x;
      b = y;
      in_tag = t;
      in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back('{c: e, tag: t, cyc: cyc});
            n_in++;
            done = 1'b1;
         end else if (waited > 200) begin
            check("accept_timeout", 1'b0, 1'b1);
            done = 1'b1;
         end else begin
            waited++;
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((sb_q.size() != 0 || busy) && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain_done", (sb_q.size() == 0 && !busy), 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WC:0]   one, f;
      logic [WA-1:0] xa;
      logic [WB-1:0] xb;
      logic [63:0]   w1;
      logic [31:0]   w2;
      logic [TW-1:0] tg;
      int            base, k;

      rst = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
      v1 = 1'b0; r1 = 1'b1; a1 = '0; b1 = '0; t1 = '0;
      v2 = 1'b0; r2 = 1'b1; a2 = '0; b2 = '0; t2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_alt_valid", ov2, 1'b0);
      check("reset_alt_busy", bz2, 1'b0);

      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1'b1);
      send(66'h3AABBCCDDAABBCCDD, 68'hF123456123456ABCD, 4'h5, 134'h3743c21f280bfbb920424b44cae078abf9);
      wait_drain();

      // Boundary operands against closed-form results.
      one = 1;
      f = (one << WC) - (one << WA) - (one << WB) + one;
      send('1, '1, 4'h1, WC'(f));
      send('0, rand_b(), 4'h2, '0);
      send(rand_a(), '0, 4'h3, '0);
      xb = rand_b();
      send(66'd1, xb, 4'h4, WC'(xb));
      wait_drain();

      // 64 back-to-back beats with consecutive tags.
      base = n_out;
      seen_first = 1'b0;
      gaps = 0;
      watch_gap = 1'b1;
      for (int i = 0; i < 64; i++) begin
         xa = rand_a();
         xb = rand_b();
         send(xa, xb, TW'(i), ref_mul(xa, xb));
      end
      wait_drain();
      watch_gap = 1'b0;
      check("stream_count", n_out - base, 64);
      check("stream_gaps", gaps, 0);

      // Random valid and random backpressure.
      base = n_out;
      k = n_in;
      rdy_rand = 1'b1;
      tg = '0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom % 2 == 1) begin
            xa = rand_a();
            xb = rand_b();
            send(xa, xb, tg, ref_mul(xa, xb));
            tg = tg + 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      rdy_rand = 1'b0;
      wait_drain();
      check("random_no_loss", n_out - base, n_in - k);

      // Reset with three beats in flight.
      send(rand_a(), rand_b(), 4'hA, '0);
      send(rand_a(), rand_b(), 4'hB, '0);
      send(rand_a(), rand_b(), 4'hC, '0);
      rst = 1'b0;
      #1;
      check("midreset_out_valid", out_valid, 1'b0);
      check("midreset_busy", busy, 1'b0);
      sb_q.delete();
      base = n_out;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("post_reset_in_ready", in_ready, 1'b1);
      xa = rand_a();
      xb = rand_b();
      send(xa, xb, 4'hD, ref_mul(xa, xb));
      repeat (20) @(posedge clk);
      #1;
      wait_drain();
      check("post_reset_results", n_out - base, 1);

      // 33x31 with every stage bypassed: purely combinational.
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         a1 = 33'({$urandom, $urandom});
         b1 = 31'($urandom);
         t1 = TW'($urandom);
         v1 = 1'($urandom % 2);
         r1 = 1'($urandom % 2);
         #1;
         w1 = 64'(a1) * 64'(b1);
         check("comb_c", c1, w1);
         check("comb_tag", ot1, t1);
         check("comb_valid", ov1, v1);
         check("comb_ready", ir1, r1);
         check("comb_busy", bz1, 1'b0);
      end

      // 16x16 with alternating stages enabled.
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         a2 = 16'($urandom);
         b2 = 16'($urandom);
         t2 = TW'(i);
         v2 = ($urandom % 4 != 0);
         @(negedge clk);
         if (v2 && ir2) begin
            w2 = 32'(a2) * 32'(b2);
            q2.push_back('{c: WC'(w2), tag: t2, cyc: cyc});
         end
      end
      @(posedge clk);
      #1;
      v2 = 1'b0;
      k = 0;
      while ((q2.size() != 0 || bz2) && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("alt_drain", (q2.size() == 0 && !bz2), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
